// File: rtl/line_mem_pkg.sv
// Shared constants, FSM state type and default-pattern helper for the line memory responder.
package line_mem_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } lmr_state_t;

    // Unwritten lines read back as their own base address repeated across all four words.
    function automatic logic [LINE_W-1:0] default_line(input logic [31:0] addr);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        return {4{base}};
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// Single-port line RAM with a per-line written flag; the flags and the read register clear
// on reset, the data RAM does not.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LINES = 1024,
    localparam int unsigned IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    input  logic [LINE_W-1:0] dflt,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0]      ram [DEPTH_LINES];
    logic [DEPTH_LINES-1:0] written_q;
    logic [LINE_W-1:0]      rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            ram[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (we) begin
                written_q[idx] <= 1'b1;
            end
            // The read register holds its value until the next read, across writes and idle time.
            if (re) begin
                rdata_q <= written_q[idx] ? ram[idx] : dflt;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder: captures one line request, waits LATENCY edges, then commits the
// write or returns the read line alongside a one-cycle ready pulse.
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LINES = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_dataout,
    input  logic              mem_req_rw,
    input  logic              mem_req_valid,
    output logic [LINE_W-1:0] mem_req_datain,
    output logic              mem_req_ready,
    output logic              busy
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_LINES);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    lmr_state_t        state_q;
    logic [3:0]        cnt_q;
    logic [31:0]       addr_q;
    logic              rw_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ready_q;
    logic              busy_q;

    logic              from_idle;
    logic              enter_resp;
    logic [31:0]       c_addr;
    logic              c_rw;
    logic [LINE_W-1:0] c_wdata;

    // With LATENCY=1 the commit happens on the accept edge, so it must use the live inputs.
    always_comb begin
        from_idle  = (state_q == StIdle);
        c_addr     = from_idle ? mem_req_addr    : addr_q;
        c_rw       = from_idle ? mem_req_rw      : rw_q;
        c_wdata    = from_idle ? mem_req_dataout : wdata_q;
        enter_resp = (from_idle && mem_req_valid && (LATENCY == 1))
                   || ((state_q == StBusy) && (cnt_q == 4'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_req_valid) begin
                        addr_q  <= mem_req_addr;
                        rw_q    <= mem_req_rw;
                        wdata_q <= mem_req_dataout;
                        busy_q  <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= StResp;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    line_mem_array #(
        .DEPTH_LINES(DEPTH_LINES)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (enter_resp && c_rw),
        .re   (enter_resp && !c_rw),
        .idx  (c_addr[OFFSET_BITS +: IDX_W]),
        .wdata(c_wdata),
        .dflt (default_line(c_addr)),
        .rdata(mem_req_datain)
    );

    assign mem_req_ready = ready_q;
    assign busy          = busy_q;

endmodule
